// File: rtl/bus_if_types_pkg.sv
// Shared SoC bus transfer types.
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

endpackage

// File: rtl/gpio_regs_pkg.sv
// GPIO register offsets and interrupt type encoding.
package gpio_regs_pkg;

  localparam logic [7:0] GPIO_IN       = 8'h00;
  localparam logic [7:0] GPIO_OE       = 8'h04;
  localparam logic [7:0] GPIO_OUT      = 8'h08;
  localparam logic [7:0] GPIO_OUT_SET  = 8'h0C;
  localparam logic [7:0] GPIO_OUT_CLR  = 8'h10;
  localparam logic [7:0] GPIO_OUT_TGL  = 8'h14;
  localparam logic [7:0] GPIO_IRQ_EN   = 8'h18;
  localparam logic [7:0] GPIO_IRQ_TYPE = 8'h1C;
  localparam logic [7:0] GPIO_IRQ_POL  = 8'h20;
  localparam logic [7:0] GPIO_IRQ_PEND = 8'h24;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_type_e;

endpackage

// File: rtl/slave_bus_if.sv
// Simple single-cycle SoC bus between a master and a memory-mapped slave.
interface slave_bus_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  import bus_if_types_pkg::*;

  logic              ss;
  ttype_e            ttype;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              bdone;

  modport master (output ss, ttype, addr, wdata, input rdata, bdone);
  modport slave  (input ss, ttype, addr, wdata, output rdata, bdone);

endinterface

// File: rtl/IOBUF.sv
// Behavioural bidirectional pad buffer; OEN low drives the pad.
module IOBUF (
  input  logic      I,
  input  logic      OEN,
  output logic      O,
  inout  wire logic IO
);

  assign IO = OEN ? 1'bz : I;
  assign O  = IO;

endmodule

// File: rtl/gpio_pad_bank.sv
// Bank of N_GPIO bidirectional pad buffers.
module gpio_pad_bank #(
  parameter int unsigned N_GPIO = 8
) (
  input  logic [N_GPIO-1:0] out_val,
  input  logic [N_GPIO-1:0] out_en,
  output logic [N_GPIO-1:0] in_val,
  inout  wire logic [N_GPIO-1:0] gpio
);

  for (genvar i = 0; i < N_GPIO; i++) begin : g_pad
    IOBUF u_iobuf (
      .I   (out_val[i]),
      .OEN (~out_en[i]),
      .O   (in_val[i]),
      .IO  (gpio[i])
    );
  end

endmodule

// File: rtl/gpio_ctrl.sv
// N-pin GPIO controller: pad bank, input synchroniser, atomic output updates
// and per-pin edge/level interrupts behind a memory-mapped slave port.
module gpio_ctrl
  import bus_if_types_pkg::*;
  import gpio_regs_pkg::*;
#(
  parameter int unsigned N_GPIO      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  slave_bus_if.slave             bus,
  inout  wire logic [N_GPIO-1:0] gpio,
  output logic                   irq
);

  logic [N_GPIO-1:0] oe_q, out_q, en_q, type_q, pol_q, pend_q;
  logic [N_GPIO-1:0] oe_d, out_d, en_d, type_d, pol_d, pend_d;
  logic [N_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [N_GPIO-1:0] pad_in, in_q, prev_q;
  logic [N_GPIO-1:0] hit, level_pend, pend, w1c, wdata_n, rdata_n;
  logic              wr_en;
  logic              unused_bits;

  gpio_pad_bank #(.N_GPIO(N_GPIO)) u_pads (
    .out_val (out_q),
    .out_en  (oe_q),
    .in_val  (pad_in),
    .gpio    (gpio)
  );

  assign wr_en       = bus.ss && (bus.ttype == WRITE);
  assign wdata_n     = bus.wdata[N_GPIO-1:0];
  assign bus.bdone   = 1'b1;
  assign unused_bits = ^{bus.addr, bus.wdata};

  always_comb begin
    in_q = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    hit        = '0;
    level_pend = '0;
    for (int unsigned i = 0; i < N_GPIO; i++) begin
      if (en_q[i]) begin
        if (irq_type_e'(type_q[i]) == IRQ_EDGE)
          hit[i] = pol_q[i] ? (in_q[i] & ~prev_q[i]) : (~in_q[i] & prev_q[i]);
        else
          level_pend[i] = (in_q[i] == pol_q[i]);
      end
    end
    pend = (pend_q & type_q) | level_pend;
  end

  always_comb begin
    oe_d   = oe_q;
    out_d  = out_q;
    en_d   = en_q;
    type_d = type_q;
    pol_d  = pol_q;
    w1c    = '0;
    if (wr_en) begin
      case (bus.addr[7:0])
        GPIO_OE:       oe_d   = wdata_n;
        GPIO_OUT:      out_d  = wdata_n;
        GPIO_OUT_SET:  out_d  = out_q | wdata_n;
        GPIO_OUT_CLR:  out_d  = out_q & ~wdata_n;
        GPIO_OUT_TGL:  out_d  = out_q ^ wdata_n;
        GPIO_IRQ_EN:   en_d   = wdata_n;
        GPIO_IRQ_TYPE: type_d = wdata_n;
        GPIO_IRQ_POL:  pol_d  = wdata_n;
        GPIO_IRQ_PEND: w1c    = wdata_n;
        default: ;
      endcase
    end
    // New edges override a same-cycle W1C; masking with the next type drops
    // stored bits for pins switching to level mode.
    pend_d = ((pend_q & ~w1c) | hit) & type_d;
  end

  always_comb begin
    rdata_n = '0;
    case (bus.addr[7:0])
      GPIO_IN:       rdata_n = in_q;
      GPIO_OE:       rdata_n = oe_q;
      GPIO_OUT:      rdata_n = out_q;
      GPIO_IRQ_EN:   rdata_n = en_q;
      GPIO_IRQ_TYPE: rdata_n = type_q;
      GPIO_IRQ_POL:  rdata_n = pol_q;
      GPIO_IRQ_PEND: rdata_n = pend;
      default:       rdata_n = '0;
    endcase
    bus.rdata              = '0;
    bus.rdata[N_GPIO-1:0]  = rdata_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q   <= '0;
      out_q  <= '0;
      en_q   <= '0;
      type_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      prev_q <= '0;
      irq    <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      oe_q   <= oe_d;
      out_q  <= out_d;
      en_q   <= en_d;
      type_q <= type_d;
      pol_q  <= pol_d;
      pend_q <= pend_d;
      prev_q <= in_q;
      irq    <= |(pend & en_q);
      sync_q[0] <= pad_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboarded bench for gpio_ctrl: directed timing cases plus randomized
// register/pin traffic checked against a transaction-level model.
module tb_gpio_ctrl;
  import bus_if_types_pkg::*;
  import gpio_regs_pkg::*;

  typedef enum int unsigned { K_IRQ, K_PINS, K_BDONE } aux_kind_e;
  typedef struct { string name; logic [31:0] exp; } exp_t;
  typedef struct { string name; aux_kind_e kind; logic [31:0] exp; } aux_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  slave_bus_if bus8 ();
  slave_bus_if bus4 ();

  logic [7:0] tb_en8 = 8'hFF, tb_drv8 = 8'h00;
  logic [3:0] tb_en4 = 4'hF,  tb_drv4 = 4'h0;
  wire  [7:0] pins8;
  wire  [3:0] pins4;
  logic       irq8, irq4;

  for (genvar i = 0; i < 8; i++) begin : g_drv8
    assign pins8[i] = tb_en8[i] ? tb_drv8[i] : 1'bz;
  end
  for (genvar i = 0; i < 4; i++) begin : g_drv4
    assign pins4[i] = tb_en4[i] ? tb_drv4[i] : 1'bz;
  end

  gpio_ctrl #(.N_GPIO(8), .SYNC_STAGES(2)) dut (
    .clk (clk), .rst (rst), .bus (bus8), .gpio (pins8), .irq (irq8)
  );

  gpio_ctrl #(.N_GPIO(4), .SYNC_STAGES(2)) dut4 (
    .clk (clk), .rst (rst4), .bus (bus4), .gpio (pins4), .irq (irq4)
  );

  int   checks = 0;
  int   passes = 0;
  exp_t rd_q8[$], rd_q4[$];
  aux_t aux_q8[$], aux_q4[$];
  logic aux_chk8 = 1'b0, aux_chk4 = 1'b0;

  function automatic void do_check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void orphan(string name);
    checks++;
    $display("FAIL %s: DUT output with no queued expectation", name);
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    aux_t a;
    if (bus8.ss && bus8.ttype == READ) begin
      if (rd_q8.size() == 0) orphan("rd8");
      else begin e = rd_q8.pop_front(); do_check(e.name, bus8.rdata, e.exp); end
    end
    if (bus4.ss && bus4.ttype == READ) begin
      if (rd_q4.size() == 0) orphan("rd4");
      else begin e = rd_q4.pop_front(); do_check(e.name, bus4.rdata, e.exp); end
    end
    if (aux_chk8) begin
      if (aux_q8.size() == 0) orphan("aux8");
      else begin
        a = aux_q8.pop_front();
        case (a.kind)
          K_IRQ:   do_check(a.name, {31'd0, irq8}, a.exp);
          K_PINS:  do_check(a.name, {24'd0, pins8}, a.exp);
          default: do_check(a.name, {31'd0, bus8.bdone}, a.exp);
        endcase
      end
    end
    if (aux_chk4) begin
      if (aux_q4.size() == 0) orphan("aux4");
      else begin a = aux_q4.pop_front(); do_check(a.name, {31'd0, irq4}, a.exp); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [7:0] a, input logic [31:0] d);
    if (a == GPIO_OE) tb_en8 = tb_en8 & ~d[7:0];
    bus8.ss = 1'b1; bus8.ttype = WRITE; bus8.addr = {24'd0, a}; bus8.wdata = d;
    tick(1);
    bus8.ss = 1'b0; bus8.ttype = READ;
    if (a == GPIO_OE) tb_en8 = ~d[7:0];
  endtask

  task automatic rd8(input logic [7:0] a, input logic [31:0] exp, input string name);
    rd_q8.push_back('{name, exp});
    bus8.ss = 1'b1; bus8.ttype = READ; bus8.addr = {24'd0, a};
    tick(1);
    bus8.ss = 1'b0;
  endtask

  task automatic aux8(input aux_kind_e k, input logic [31:0] exp, input string name);
    aux_q8.push_back('{name, k, exp});
    aux_chk8 = 1'b1;
  endtask

  task automatic rdi8(input logic [7:0] a, input logic [31:0] exp, input logic ei, input string name);
    aux8(K_IRQ, {31'd0, ei}, {name, "_irq"});
    rd8(a, exp, name);
    aux_chk8 = 1'b0;
  endtask

  task automatic chk_irq8(input logic ei, input string name);
    aux8(K_IRQ, {31'd0, ei}, name);
    tick(1);
    aux_chk8 = 1'b0;
  endtask

  task automatic wr4(input logic [7:0] a, input logic [31:0] d);
    bus4.ss = 1'b1; bus4.ttype = WRITE; bus4.addr = {24'd0, a}; bus4.wdata = d;
    tick(1);
    bus4.ss = 1'b0; bus4.ttype = READ;
  endtask

  task automatic rdi4(input logic [7:0] a, input logic [31:0] exp, input logic ei, input string name);
    rd_q4.push_back('{name, exp});
    aux_q4.push_back('{{name, "_irq"}, K_IRQ, {31'd0, ei}});
    aux_chk4 = 1'b1;
    bus4.ss = 1'b1; bus4.ttype = READ; bus4.addr = {24'd0, a};
    tick(1);
    bus4.ss = 1'b0; aux_chk4 = 1'b0;
  endtask

  // Reference model for the randomized phase (pins 0-3 outputs, 4-7 inputs).
  logic [7:0] oe_m, out_m, en_m, typ_m, pol_m, pend_m, drv_m;

  function automatic logic [7:0] eff_in();
    return (out_m & oe_m) | (drv_m & ~oe_m);
  endfunction

  function automatic void edges(logic [7:0] old_in, logic [7:0] new_in);
    for (int i = 0; i < 8; i++)
      if (en_m[i] && typ_m[i] && old_in[i] != new_in[i] && new_in[i] == pol_m[i])
        pend_m[i] = 1'b1;
  endfunction

  function automatic logic [7:0] exp_pend();
    return (pend_m & typ_m) | (en_m & ~typ_m & ~(eff_in() ^ pol_m));
  endfunction

  initial begin
    #2_000_000;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    logic [7:0]  old_in;
    logic [31:0] d;
    int          op;

    bus8.ss = 1'b0; bus8.ttype = READ; bus8.addr = '0; bus8.wdata = '0;
    bus4.ss = 1'b0; bus4.ttype = READ; bus4.addr = '0; bus4.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst4 = 1'b0;

    // Reset state
    aux8(K_IRQ, 0, "rst_irq");
    rd8(GPIO_IN, 0, "rst_in");
    aux_chk8 = 1'b0;
    aux8(K_BDONE, 1, "bdone");
    rd8(GPIO_OE, 0, "rst_oe");
    aux_chk8 = 1'b0;
    for (int unsigned off = 8; off <= 8'h2C; off += 4)
      rd8(off[7:0], 0, $sformatf("rst_rd_%0h", off));

    // Atomic output updates
    wr8(GPIO_OE, 32'hFF);
    wr8(GPIO_OUT, 32'hA5);
    wr8(GPIO_OUT_SET, 32'h02);
    wr8(GPIO_OUT_CLR, 32'h80);
    wr8(GPIO_OUT_TGL, 32'h0F);
    aux8(K_PINS, 32'h28, "pins_out");
    rd8(GPIO_OUT, 32'h28, "out_val");
    aux_chk8 = 1'b0;
    rd8(GPIO_OUT_SET, 0, "set_rd0");
    tick(2);
    rd8(GPIO_IN, 32'h28, "in_readback");
    tb_drv8 = 8'h00;
    wr8(GPIO_OE, 32'h00);
    tick(4);

    // Rising edge on pin 3: latency and W1C
    wr8(GPIO_IRQ_EN, 32'h08);
    wr8(GPIO_IRQ_TYPE, 32'h08);
    wr8(GPIO_IRQ_POL, 32'h08);
    tb_drv8[3] = 1'b1;
    rd8(GPIO_IN, 0, "in_k0");
    rd8(GPIO_IN, 0, "in_k1");
    rd8(GPIO_IN, 32'h08, "in_k2");
    rdi8(GPIO_IRQ_PEND, 32'h08, 1'b0, "pend_k3");
    chk_irq8(1'b1, "irq_k4");
    wr8(GPIO_IRQ_PEND, 32'h08);
    chk_irq8(1'b1, "irq_w1c_1");
    rdi8(GPIO_IRQ_PEND, 0, 1'b0, "pend_w1c_2");
    tb_drv8[3] = 1'b0;
    tick(5);
    rdi8(GPIO_IRQ_PEND, 0, 1'b0, "pend_fall_ignored");
    wr8(GPIO_IRQ_EN, 0);

    // Level-low on pin 0
    wr8(GPIO_IRQ_TYPE, 0);
    wr8(GPIO_IRQ_POL, 0);
    wr8(GPIO_IRQ_EN, 32'h01);
    tick(1);
    rdi8(GPIO_IRQ_PEND, 32'h01, 1'b1, "lvl_pend");
    wr8(GPIO_IRQ_PEND, 32'h01);
    rd8(GPIO_IRQ_PEND, 32'h01, "lvl_w1c_noeffect");
    tb_drv8[0] = 1'b1;
    tick(4);
    rdi8(GPIO_IRQ_PEND, 0, 1'b0, "lvl_released");
    wr8(GPIO_IRQ_EN, 0);

    // W1C coinciding with a falling edge on pin 5
    tb_drv8[5] = 1'b1;
    tick(4);
    wr8(GPIO_IRQ_TYPE, 32'h20);
    wr8(GPIO_IRQ_EN, 32'h20);
    tb_drv8[5] = 1'b0;
    tick(2);
    wr8(GPIO_IRQ_PEND, 32'h20);
    rdi8(GPIO_IRQ_PEND, 32'h20, 1'b0, "set_wins");
    chk_irq8(1'b1, "set_wins_irq");
    wr8(GPIO_IRQ_PEND, 32'h20);
    rd8(GPIO_IRQ_PEND, 0, "w1c_plain");

    // Narrow instance: masking and reset mid-pend
    wr4(GPIO_OUT, 32'hFF);
    rdi4(GPIO_OUT, 32'h0F, 1'b0, "n4_out_mask");
    wr4(GPIO_IRQ_EN, 32'hFFFF_FFFF);
    rdi4(GPIO_IRQ_EN, 32'h0F, 1'b0, "n4_en_mask");
    wr4(GPIO_IRQ_TYPE, 32'h04);
    wr4(GPIO_IRQ_POL, 32'h04);
    wr4(GPIO_IRQ_EN, 32'h04);
    tb_drv4[2] = 1'b1;
    tick(5);
    rdi4(GPIO_IRQ_PEND, 32'h04, 1'b1, "n4_pend");
    rst4 = 1'b1;
    tick(1);
    rst4 = 1'b0;
    rdi4(GPIO_IRQ_PEND, 0, 1'b0, "n4_rst_pend");
    rdi4(GPIO_OUT, 0, 1'b0, "n4_rst_out");
    tick(4);
    rdi4(GPIO_IRQ_PEND, 0, 1'b0, "n4_refill_pend");
    rdi4(GPIO_IN, 32'h04, 1'b0, "n4_refill_in");

    // Randomized traffic after a mid-operation reset of the main instance
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    oe_m = 8'h0F; out_m = 0; en_m = 0; typ_m = 0; pol_m = 0; pend_m = 0;
    tb_drv8 = 8'($urandom);
    drv_m = tb_drv8;
    wr8(GPIO_OE, {24'd0, oe_m});
    tick(5);
    rd8(GPIO_IN, {24'd0, eff_in()}, "rnd_start_in");

    for (int n = 0; n < 160; n++) begin
      op = int'($urandom_range(0, 9));
      d = $urandom;
      old_in = eff_in();
      case (op)
        0: begin wr8(GPIO_OUT, d);      out_m = d[7:0]; end
        1: begin wr8(GPIO_OUT_SET, d);  out_m = out_m | d[7:0]; end
        2: begin wr8(GPIO_OUT_CLR, d);  out_m = out_m & ~d[7:0]; end
        3: begin wr8(GPIO_OUT_TGL, d);  out_m = out_m ^ d[7:0]; end
        4: begin wr8(GPIO_IRQ_EN, d);   en_m = d[7:0]; end
        5: begin wr8(GPIO_IRQ_TYPE, d); typ_m = d[7:0]; pend_m = pend_m & d[7:0]; end
        6: begin wr8(GPIO_IRQ_POL, d);  pol_m = d[7:0]; end
        7: begin wr8(GPIO_IRQ_PEND, d); pend_m = pend_m & ~(d[7:0] & typ_m); end
        default: begin tb_drv8 = d[7:0]; drv_m = d[7:0]; end
      endcase
      edges(old_in, eff_in());
      tick(6);
      rd8(GPIO_IN, {24'd0, eff_in()}, "rnd_in");
      rd8(GPIO_OUT, {24'd0, out_m}, "rnd_out");
      rdi8(GPIO_IRQ_PEND, {24'd0, exp_pend()}, |(exp_pend() & en_m), "rnd_pend");
    end

    tick(3);
    if (rd_q8.size() + rd_q4.size() + aux_q8.size() + aux_q4.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations never matched by DUT output, expected 0",
               rd_q8.size() + rd_q4.size() + aux_q8.size() + aux_q4.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
